// File: rtl/counter_pkg.sv
// counter_pkg
// Shared types and helpers for the modulo-N up/down counter.
//   op_e     : operation selected on an edge (hold / clear / load / up / down)
//   bin2gray : binary to reflected Gray code, 32 bits wide (callers truncate)
//   maxv_of  : largest legal count for a given modulus; each module derives
//              its own MAXV localparam from it
package counter_pkg;

   typedef enum logic [2:0] {
      OP_HOLD,
      OP_CLEAR,
      OP_LOAD,
      OP_UP,
      OP_DOWN
   } op_e;

   function automatic logic [31:0] bin2gray(input logic [31:0] bin);
      return bin ^ (bin >> 1);
   endfunction

   function automatic longint maxv_of(input longint modulus);
      return modulus - 64'sd1;
   endfunction

endpackage

// File: rtl/count_next.sv
// count_next
// Combinational next-state and wrap detection for the modulo-N counter.
// Parameters: WIDTH (count width), MODULUS (count range 0..MODULUS-1).
// Ports:
//   q          in  WIDTH  current registered count
//   enable     in  1      count enable
//   up         in  1      1 = up, 0 = down
//   load       in  1      parallel load request
//   load_value in  WIDTH  value to load (clamped to MODULUS-1)
//   clear      in  1      clear request (highest priority)
//   q_next     out WIDTH  count for the next edge
//   wrap_hit   out 1      this edge wraps the count
module count_next
   import counter_pkg::*;
#(
   parameter int     WIDTH   = 4,
   parameter longint MODULUS = 16
) (
   input  logic [WIDTH-1:0] q,
   input  logic             enable,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             clear,
   output logic [WIDTH-1:0] q_next,
   output logic             wrap_hit
);

   // With MODULUS = 2^WIDTH this is all ones, so the up wrap coincides with
   // natural rollover and no wider intermediate is required.
   localparam logic [WIDTH-1:0] MAXV = WIDTH'(maxv_of(MODULUS));

   op_e  op;
   logic at_max;
   logic at_zero;

   assign at_max  = (q == MAXV);
   assign at_zero = (q == '0);

   // Priority: clear > load > enable > hold.
   always_comb begin
      op = OP_HOLD;
      if (clear) begin
         op = OP_CLEAR;
      end else if (load) begin
         op = OP_LOAD;
      end else if (enable) begin
         op = up ? OP_UP : OP_DOWN;
      end
   end

   always_comb begin
      q_next   = q;
      wrap_hit = 1'b0;
      case (op)
         OP_CLEAR: q_next = '0;
         // Out-of-range loads clamp to the top of the range; a load is never a wrap.
         OP_LOAD:  q_next = (load_value > MAXV) ? MAXV : load_value;
         OP_UP: begin
            q_next   = at_max ? '0 : q + WIDTH'(1);
            wrap_hit = at_max;
         end
         OP_DOWN: begin
            q_next   = at_zero ? MAXV : q - WIDTH'(1);
            wrap_hit = at_zero;
         end
         default: q_next = q;
      endcase
   end

endmodule

// File: rtl/mod_updown_counter.sv
// mod_updown_counter
// Synchronous modulo-N up/down counter with enable, parallel load (clamped),
// synchronous clear, cascadable terminal count and wrap/overflow flags.
// Optional feature macro: COUNTER_GRAY_OUT_EN adds a registered Gray output.
// Parameters: WIDTH (1..32), MODULUS (2..2^WIDTH), RESET_VALUE (< MODULUS).
// Ports:
//   clock      in  1      rising-edge clock
//   reset      in  1      asynchronous active-high reset
//   enable     in  1      count enable, also gates tc
//   up         in  1      1 = count up, 0 = count down
//   load       in  1      synchronous parallel load
//   load_value in  WIDTH  load data
//   clear      in  1      synchronous clear of q, wrap and overflow
//   q          out WIDTH  registered count
//   qb         out WIDTH  ~q
//   tc         out 1      combinational terminal count for cascading
//   wrap       out 1      one-cycle pulse while q shows the wrapped value
//   overflow   out 1      sticky wrap flag
//   gray       out WIDTH  registered Gray code of q (COUNTER_GRAY_OUT_EN only)
module mod_updown_counter
   import counter_pkg::*;
#(
   parameter int     WIDTH       = 4,
   parameter longint MODULUS     = 16,
   parameter longint RESET_VALUE = 0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             clear,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qb,
   output logic             tc,
   output logic             wrap,
   output logic             overflow
`ifdef COUNTER_GRAY_OUT_EN
   ,
   output logic [WIDTH-1:0] gray
`endif
);

   generate
      if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
         $error("mod_updown_counter: WIDTH must be 1..32");
      end
      if (MODULUS < longint'(2) || MODULUS > (longint'(1) << WIDTH)) begin : g_bad_modulus
         $error("mod_updown_counter: MODULUS must be 2..2^WIDTH");
      end
      if (RESET_VALUE < longint'(0) || RESET_VALUE >= MODULUS) begin : g_bad_reset
         $error("mod_updown_counter: RESET_VALUE must be below MODULUS");
      end
   endgenerate

   localparam logic [WIDTH-1:0] MAXV  = WIDTH'(maxv_of(MODULUS));
   localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VALUE);

   logic [WIDTH-1:0] q_next;
   logic             wrap_hit;

   count_next #(
      .WIDTH   (WIDTH),
      .MODULUS (MODULUS)
   ) u_count_next (
      .q          (q),
      .enable     (enable),
      .up         (up),
      .load       (load),
      .load_value (load_value),
      .clear      (clear),
      .q_next     (q_next),
      .wrap_hit   (wrap_hit)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         q        <= RST_Q;
         wrap     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         q    <= q_next;
         // wrap_hit is already low under clear, so the pulse clears with it.
         wrap <= wrap_hit;
         if (clear) begin
            overflow <= 1'b0;
         end else if (wrap_hit) begin
            overflow <= 1'b1;
         end
      end
   end

`ifdef COUNTER_GRAY_OUT_EN
   // Registered from the next count so it changes on the same edge as q,
   // giving a glitch-free bus for synchronisers in another clock domain.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         gray <= WIDTH'(bin2gray(32'(RST_Q)));
      end else begin
         gray <= WIDTH'(bin2gray(32'(q_next)));
      end
   end
`endif

   assign qb = ~q;
   assign tc = enable & ((up & (q == MAXV)) | (~up & (q == '0)));

endmodule

// File: tb/tb_mod_updown_counter.sv
module tb_mod_updown_counter;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   int vectors     = 0;
   int miscompares = 0;

   // ---------------- instance A: WIDTH=4, MODULUS=10, RESET_VALUE=3
   logic       a_reset, a_enable, a_up, a_load, a_clear;
   logic [3:0] a_lv, a_q, a_qb;
   logic       a_tc, a_wrap, a_ovf;
`ifdef COUNTER_GRAY_OUT_EN
   logic [3:0] a_gray;
`endif

   mod_updown_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(3)) dut_a (
      .clock(clock), .reset(a_reset), .enable(a_enable), .up(a_up),
      .load(a_load), .load_value(a_lv), .clear(a_clear),
      .q(a_q), .qb(a_qb), .tc(a_tc), .wrap(a_wrap), .overflow(a_ovf)
`ifdef COUNTER_GRAY_OUT_EN
      , .gray(a_gray)
`endif
   );

   // ---------------- cascade: two decade stages, stage 1 enabled by stage 0 tc
   logic       b_reset, c_en, c_clear;
   logic [3:0] c0_q, c0_qb, c1_q, c1_qb;
   logic       c0_tc, c0_wrap, c0_ovf, c1_tc, c1_wrap, c1_ovf;
`ifdef COUNTER_GRAY_OUT_EN
   logic [3:0] c0_gray, c1_gray;
`endif

   mod_updown_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) dut_c0 (
      .clock(clock), .reset(b_reset), .enable(c_en), .up(1'b1),
      .load(1'b0), .load_value(4'd0), .clear(c_clear),
      .q(c0_q), .qb(c0_qb), .tc(c0_tc), .wrap(c0_wrap), .overflow(c0_ovf)
`ifdef COUNTER_GRAY_OUT_EN
      , .gray(c0_gray)
`endif
   );

   mod_updown_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) dut_c1 (
      .clock(clock), .reset(b_reset), .enable(c0_tc), .up(1'b1),
      .load(1'b0), .load_value(4'd0), .clear(c_clear),
      .q(c1_q), .qb(c1_qb), .tc(c1_tc), .wrap(c1_wrap), .overflow(c1_ovf)
`ifdef COUNTER_GRAY_OUT_EN
      , .gray(c1_gray)
`endif
   );

`ifdef COUNTER_GRAY_OUT_EN
   // ---------------- Gray instance: WIDTH=4, MODULUS=16
   logic       g_en, g_clear;
   logic [3:0] g_q, g_qb, g_gray;
   logic       g_tc, g_wrap, g_ovf;

   mod_updown_counter #(.WIDTH(4), .MODULUS(16), .RESET_VALUE(0)) dut_g (
      .clock(clock), .reset(b_reset), .enable(g_en), .up(1'b1),
      .load(1'b0), .load_value(4'd0), .clear(g_clear),
      .q(g_q), .qb(g_qb), .tc(g_tc), .wrap(g_wrap), .overflow(g_ovf),
      .gray(g_gray)
   );
`endif

   // ---------------- scoreboard and reference model for instance A
   typedef struct packed {
      logic       c;
      logic       l;
      logic [3:0] lv;
      logic       e;
      logic       u;
   } stim_t;

   typedef struct packed {
      logic [3:0] q;
      logic       wrap;
      logic       ovf;
   } exp_t;

   exp_t       sb_a[$];
   logic [3:0] m_q;
   logic       m_wrap, m_ovf;

   function automatic stim_t mk(input logic c, input logic l, input logic [3:0] lv,
                                input logic e, input logic u);
      stim_t s;
      s.c = c; s.l = l; s.lv = lv; s.e = e; s.u = u;
      return s;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Drive one set of inputs, predict tc/qb for the present count and push
   // the state expected after the coming edge.
   task automatic set_a(input stim_t s, output logic exp_tc, output logic [3:0] exp_qb);
      a_clear = s.c; a_load = s.l; a_lv = s.lv; a_enable = s.e; a_up = s.u;
      #1;
      exp_tc = s.e && ((s.u && m_q == 4'd9) || (!s.u && m_q == 4'd0));
      exp_qb = ~m_q;
      m_wrap = 1'b0;
      if (s.c) begin
         m_q = 4'd0; m_ovf = 1'b0;
      end else if (s.l) begin
         m_q = (s.lv > 4'd9) ? 4'd9 : s.lv;
      end else if (s.e) begin
         if (s.u) begin
            if (m_q == 4'd9) begin m_q = 4'd0; m_wrap = 1'b1; end
            else m_q = m_q + 4'd1;
         end else begin
            if (m_q == 4'd0) begin m_q = 4'd9; m_wrap = 1'b1; end
            else m_q = m_q - 4'd1;
         end
      end
      if (m_wrap) m_ovf = 1'b1;
      sb_a.push_back('{q: m_q, wrap: m_wrap, ovf: m_ovf});
   endtask

   // ---------------- tests
   task automatic test_reset();
      exp_t       ex;
      logic       etc;
      logic [3:0] eqb;
      // power-up reset pulse, checked before the first clock edge
      a_reset = 1'b0; b_reset = 1'b0;
      #1;
      a_reset = 1'b1; b_reset = 1'b1;
      #1;
      vectors++; if (a_q !== 4'd3) begin miscompares++; $display("FAIL reset_q got %0d want 3", a_q); end
      vectors++; if (a_qb !== 4'hC) begin miscompares++; $display("FAIL reset_qb got %h want c", a_qb); end
      vectors++; if (a_wrap !== 1'b0) begin miscompares++; $display("FAIL reset_wrap got %b want 0", a_wrap); end
      vectors++; if (a_ovf !== 1'b0) begin miscompares++; $display("FAIL reset_ovf got %b want 0", a_ovf); end
`ifdef COUNTER_GRAY_OUT_EN
      vectors++; if (a_gray !== 4'd2) begin miscompares++; $display("FAIL reset_gray got %h want 2", a_gray); end
`endif
      #1;
      a_reset = 1'b0; b_reset = 1'b0;
      m_q = 4'd3; m_wrap = 1'b0; m_ovf = 1'b0;
      // count up from 3 through a wrap and on to 7
      for (int i = 0; i < 14; i++) begin
         set_a(mk(1'b0, 1'b0, 4'd0, 1'b1, 1'b1), etc, eqb);
         vectors++; if (a_tc !== etc) begin miscompares++; $display("FAIL rst_cnt_tc step %0d got %b want %b", i, a_tc, etc); end
         vectors++; if (a_qb !== eqb) begin miscompares++; $display("FAIL rst_cnt_qb step %0d got %h want %h", i, a_qb, eqb); end
         tick();
         ex = sb_a.pop_front();
         vectors++; if (a_q !== ex.q) begin miscompares++; $display("FAIL rst_cnt_q step %0d got %0d want %0d", i, a_q, ex.q); end
         vectors++; if (a_wrap !== ex.wrap) begin miscompares++; $display("FAIL rst_cnt_wrap step %0d got %b want %b", i, a_wrap, ex.wrap); end
         vectors++; if (a_ovf !== ex.ovf) begin miscompares++; $display("FAIL rst_cnt_ovf step %0d got %b want %b", i, a_ovf, ex.ovf); end
         $display("reset-count step %0d: q=%0d wrap=%b ovf=%b", i, a_q, a_wrap, a_ovf);
      end
      // mid-cycle reset with enable still high: takes effect with no clock edge
      #2;
      a_reset = 1'b1;
      #1;
      vectors++; if (a_q !== 4'd3) begin miscompares++; $display("FAIL async_reset_q got %0d want 3", a_q); end
      vectors++; if (a_wrap !== 1'b0) begin miscompares++; $display("FAIL async_reset_wrap got %b want 0", a_wrap); end
      vectors++; if (a_ovf !== 1'b0) begin miscompares++; $display("FAIL async_reset_ovf got %b want 0", a_ovf); end
      $display("async reset: q=%0d wrap=%b ovf=%b", a_q, a_wrap, a_ovf);
      #1;
      a_reset = 1'b0;
      m_q = 4'd3; m_wrap = 1'b0; m_ovf = 1'b0;
   endtask

   task automatic run_table_a(input string name, input stim_t tbl[$]);
      exp_t       ex;
      logic       etc;
      logic [3:0] eqb;
      foreach (tbl[i]) begin
         set_a(tbl[i], etc, eqb);
         vectors++; if (a_tc !== etc) begin miscompares++; $display("FAIL %s_tc step %0d got %b want %b", name, i, a_tc, etc); end
         vectors++; if (a_qb !== eqb) begin miscompares++; $display("FAIL %s_qb step %0d got %h want %h", name, i, a_qb, eqb); end
         tick();
         ex = sb_a.pop_front();
         vectors++; if (a_q !== ex.q) begin miscompares++; $display("FAIL %s_q step %0d got %0d want %0d", name, i, a_q, ex.q); end
         vectors++; if (a_wrap !== ex.wrap) begin miscompares++; $display("FAIL %s_wrap step %0d got %b want %b", name, i, a_wrap, ex.wrap); end
         vectors++; if (a_ovf !== ex.ovf) begin miscompares++; $display("FAIL %s_ovf step %0d got %b want %b", name, i, a_ovf, ex.ovf); end
         $display("%s step %0d: c=%b l=%b lv=%0d e=%b u=%b -> q=%0d tc_pre=%b wrap=%b ovf=%b",
                  name, i, tbl[i].c, tbl[i].l, tbl[i].lv, tbl[i].e, tbl[i].u, a_q, etc, a_wrap, a_ovf);
      end
   endtask

   task automatic test_up_wrap();
      stim_t tbl[$];
      tbl.push_back(mk(1'b1, 1'b0, 4'd0, 1'b0, 1'b1));          // clear to 0
      for (int i = 0; i < 12; i++) tbl.push_back(mk(1'b0, 1'b0, 4'd0, 1'b1, 1'b1));
      run_table_a("up_wrap", tbl);
   endtask

   task automatic test_down_wrap();
      stim_t tbl[$];
      tbl.push_back(mk(1'b0, 1'b1, 4'd1, 1'b1, 1'b0));          // load 1
      tbl.push_back(mk(1'b0, 1'b0, 4'd0, 1'b1, 1'b0));          // 0
      tbl.push_back(mk(1'b0, 1'b0, 4'd0, 1'b1, 1'b0));          // 9, wrap
      tbl.push_back(mk(1'b0, 1'b0, 4'd0, 1'b1, 1'b1));          // up: 0, wrap
      tbl.push_back(mk(1'b0, 1'b0, 4'd0, 1'b1, 1'b1));          // 1
      tbl.push_back(mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0));          // hold
      tbl.push_back(mk(1'b0, 1'b0, 4'd0, 1'b1, 1'b0));          // 0
      tbl.push_back(mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0));          // hold at 0, tc gated off
      run_table_a("down_wrap", tbl);
   endtask

   task automatic test_priority();
      stim_t tbl[$];
      tbl.push_back(mk(1'b0, 1'b1, 4'd12, 1'b0, 1'b1));         // clamp -> 9
      tbl.push_back(mk(1'b0, 1'b1, 4'd15, 1'b1, 1'b1));         // clamp, tc=1 but load wins, no wrap
      tbl.push_back(mk(1'b1, 1'b1, 4'd5,  1'b1, 1'b1));         // clear beats load -> 0
      tbl.push_back(mk(1'b0, 1'b1, 4'd5,  1'b1, 1'b1));         // load beats count -> 5
      tbl.push_back(mk(1'b0, 1'b1, 4'd0,  1'b1, 1'b0));         // load 0 while counting down
      tbl.push_back(mk(1'b0, 1'b1, 4'd9,  1'b1, 1'b0));         // tc=1 at 0, load 9, no wrap
      tbl.push_back(mk(1'b0, 1'b0, 4'd0,  1'b1, 1'b1));         // 9 -> 0 wrap, ovf set
      tbl.push_back(mk(1'b0, 1'b1, 4'd10, 1'b0, 1'b0));         // boundary clamp -> 9
      tbl.push_back(mk(1'b1, 1'b0, 4'd0,  1'b1, 1'b1));         // clear at 9 with tc=1: no wrap
      run_table_a("priority", tbl);
   endtask

   task automatic test_cascade();
      typedef struct packed {
         logic [3:0] hi;
         logic [3:0] lo;
         logic       wh;
         logic       wl;
      } cexp_t;
      cexp_t      sb_c[$];
      cexp_t      ex;
      logic [3:0] hi_m, lo_m;
      logic       wh, wl;
      c_clear = 1'b1; c_en = 1'b0;
      tick();
      c_clear = 1'b0;
      hi_m = 4'd0; lo_m = 4'd0;
      vectors++; if ({c1_q, c0_q} !== 8'h00) begin miscompares++; $display("FAIL cascade_clear got %0d:%0d want 0:0", c1_q, c0_q); end
      c_en = 1'b1;
      for (int i = 1; i <= 137; i++) begin
         wl = 1'b0; wh = 1'b0;
         if (lo_m == 4'd9) begin
            lo_m = 4'd0; wl = 1'b1;
            if (hi_m == 4'd9) begin hi_m = 4'd0; wh = 1'b1; end
            else hi_m = hi_m + 4'd1;
         end else begin
            lo_m = lo_m + 4'd1;
         end
         sb_c.push_back('{hi: hi_m, lo: lo_m, wh: wh, wl: wl});
         tick();
         ex = sb_c.pop_front();
         vectors++;
         if ({c1_q, c0_q, c1_wrap, c0_wrap} !== {ex.hi, ex.lo, ex.wh, ex.wl}) begin
            miscompares++;
            $display("FAIL cascade cycle %0d got %0d:%0d wrap %b%b want %0d:%0d wrap %b%b",
                     i, c1_q, c0_q, c1_wrap, c0_wrap, ex.hi, ex.lo, ex.wh, ex.wl);
         end
         $display("cascade cycle %0d: %0d:%0d wrap=%b%b", i, c1_q, c0_q, c1_wrap, c0_wrap);
         if (i == 100) begin
            vectors++;
            if ({c1_q, c0_q, c1_wrap, c0_wrap} !== 10'b0000_0000_11) begin
               miscompares++;
               $display("FAIL cascade_100 got %0d:%0d wrap %b%b want 0:0 wrap 11", c1_q, c0_q, c1_wrap, c0_wrap);
            end
         end
      end
      c_en = 1'b0;
      vectors++; if ({c1_q, c0_q} !== 8'h37) begin miscompares++; $display("FAIL cascade_137 got %0d:%0d want 3:7", c1_q, c0_q); end
      vectors++; if ({c1_ovf, c0_ovf} !== 2'b11) begin miscompares++; $display("FAIL cascade_ovf got %b%b want 11", c1_ovf, c0_ovf); end
   endtask

   task automatic test_gray();
`ifdef COUNTER_GRAY_OUT_EN
      logic [3:0] gq[$];
      logic [3:0] gm, want, prev;
      g_clear = 1'b1; g_en = 1'b0;
      tick();
      g_clear = 1'b0;
      vectors++; if (g_gray !== 4'd0) begin miscompares++; $display("FAIL gray_clear got %h want 0", g_gray); end
      gm = 4'd0;
      prev = g_gray;
      g_en = 1'b1;
      for (int i = 0; i < 17; i++) begin
         gm = gm + 4'd1;                       // modulus 16: natural rollover
         gq.push_back(gm);
         tick();
         want = gq.pop_front();
         vectors++; if (g_q !== want) begin miscompares++; $display("FAIL gray_q step %0d got %0d want %0d", i, g_q, want); end
         vectors++; if (g_gray !== (want ^ (want >> 1))) begin miscompares++; $display("FAIL gray_code step %0d got %h want %h", i, g_gray, want ^ (want >> 1)); end
         vectors++; if ($countones(g_gray ^ prev) != 1) begin miscompares++; $display("FAIL gray_hamming step %0d got %0d bits want 1", i, $countones(g_gray ^ prev)); end
         $display("gray step %0d: q=%0d gray=%h", i, g_q, g_gray);
         prev = g_gray;
      end
      g_en = 1'b0;
`endif
   endtask

   initial begin
      a_enable = 1'b0; a_up = 1'b1; a_load = 1'b0; a_clear = 1'b0; a_lv = 4'd0;
      c_en = 1'b0; c_clear = 1'b0;
`ifdef COUNTER_GRAY_OUT_EN
      g_en = 1'b0; g_clear = 1'b0;
`endif
      test_reset();
      test_up_wrap();
      test_down_wrap();
      test_priority();
      test_cascade();
      test_gray();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
